// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_ctrl_pkg;
  localparam int          DW_DEF    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;
endpackage

// File: rtl/imem_word_counter.sv
// Word counter for the loader: synchronous clear, increment that saturates at MAX.
module imem_word_counter #(
  parameter int MAX = 1024,
  parameter int W   = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);
  logic [W-1:0] count_q;

  assign count  = count_q;
  assign at_max = (count_q == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr)          count_q <= '0;
    else if (inc && !at_max) count_q <= count_q + 1'b1;
  end
endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory sequencer: optional zero-fill, program load, then gated fetch.
// Define IMEM_CLEAR_EN to zero the whole memory after every reset.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic [31:0]   fetch_addr,
  output logic [DW-1:0] fetch_instr,
  output logic          fetch_stall,
  output logic          fetch_fault,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   prog_len,
  output logic          ld_overflow
);
`ifdef IMEM_CLEAR_EN
  localparam state_e RST_ST = ST_CLEAR;
`else
  localparam state_e RST_ST = ST_LOAD;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wcnt;
  logic          wcnt_max, cnt_clr, cnt_inc;

  imem_word_counter #(.MAX(DEPTH), .W(AW+1)) u_wcnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (wcnt),
    .at_max (wcnt_max)
  );

  // Outputs are qualified by rst so the reset cycle itself shows idle values.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    ovf_d      = ovf_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wcnt[AW-1:0];
    mem_wdata  = DW'(NOP_INSTR);
    if (!rst) begin
      case (state_q)
`ifdef IMEM_CLEAR_EN
        ST_CLEAR: begin
          mem_we  = 1'b1;
          cnt_inc = 1'b1;
          if (wcnt == (AW+1)'(DEPTH-1)) begin
            cnt_clr = 1'b1;
            state_d = ST_LOAD;
          end
        end
`endif
        ST_LOAD: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            if (!wcnt_max) begin
              mem_we    = 1'b1;
              mem_wdata = ld_data;
              cnt_inc   = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
            if (ld_last) begin
              prog_len_d = wcnt_max ? (AW+1)'(DEPTH) : wcnt + 1'b1;
              state_d    = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (reload) begin
            state_d = ST_LOAD;
            cnt_clr = 1'b1;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = RST_ST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_ST;
      prog_len_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      ovf_q      <= ovf_d;
    end
  end

  logic        run, fault_c;
  logic [29:0] fword;

  // Word-index compare against prog_len also rejects any nonzero upper address bits.
  assign run     = (state_q == ST_RUN) && !rst;
  assign fword   = fetch_addr[31:2];
  assign fault_c = (fetch_addr[1:0] != 2'b00) || (fword >= 30'(prog_len_q));

  assign fetch_stall = !run;
  assign fetch_fault = run && fault_c;
  assign fetch_instr = (run && !fault_c) ? mem_rdata : DW'(NOP_INSTR);
  assign mem_raddr   = run ? fetch_addr[AW+1:2] : '0;
  assign prog_len    = prog_len_q;
  assign ld_overflow = ovf_q;
endmodule
